// File: rtl/reload_counter_if.sv
// Reload handshake bundle between the threshold controller (master, initiator)
// and the reload counter (slave, responder). Four-phase level req/ack plus the
// value the responder loads when it services a request.
interface reload_counter_if #(
   parameter int SIZE = 8
);
   logic            reload_req;
   logic            reload_ack;
   logic [SIZE-1:0] initval;

   modport master (
      output reload_req,
      output initval,
      input  reload_ack
   );

   modport slave (
      input  reload_req,
      input  initval,
      output reload_ack
   );
endinterface

// File: rtl/reload_counter.sv
// Loadable up-counter answering reload requests over a four-phase req/ack
// handshake, followed by a hold-off window before counting resumes.
// Optional build macro: SATURATE_EN -- clamp at the maximum count instead of
// wrapping; wrap then pulses once on reaching the clamp.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_COUNT    | normal operation, out advances by STEP when en is high
// ST_RELOAD   | load initval, raise ack
// ST_ACK_WAIT | ack held high until the initiator drops req
// ST_HOLD     | out frozen for HOLDOFF cycles; a new req restarts reload
module reload_counter #(
   parameter int SIZE    = 8,
   parameter int STEP    = 1,
   parameter int HOLDOFF = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   reload_counter_if.slave rif,
   output logic [SIZE-1:0] out,
   output logic            wrap,
   output logic            busy
);

   localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

   typedef enum logic [1:0] {
      ST_COUNT    = 2'd0,
      ST_RELOAD   = 2'd1,
      ST_ACK_WAIT = 2'd2,
      ST_HOLD     = 2'd3
   } state_t;

   state_t        state;
   logic [HW-1:0] hold_cnt;
   logic [SIZE:0] sum;
`ifdef SATURATE_EN
   logic          sat;
`endif

   // Carry bit of sum marks an overflow past the top of the count range.
   assign sum  = {1'b0, out} + (SIZE + 1)'(STEP);
   assign busy = (state != ST_COUNT);

   // Sequencer: counting, reload handshake and hold-off window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_COUNT;
         out            <= '0;
         rif.reload_ack <= 1'b0;
         wrap           <= 1'b0;
         hold_cnt       <= '0;
`ifdef SATURATE_EN
         sat            <= 1'b0;
`endif
      end else begin
         wrap <= 1'b0;
         case (state)
            ST_COUNT: begin
               if (rif.reload_req) begin
                  state <= ST_RELOAD;
               end else if (en) begin
                  if (sum[SIZE]) begin
`ifdef SATURATE_EN
                     out <= '1;
                     sat <= 1'b1;
                     if (!sat) wrap <= 1'b1;
`else
                     out  <= sum[SIZE-1:0];
                     wrap <= 1'b1;
`endif
                  end else begin
                     out <= sum[SIZE-1:0];
                  end
               end
            end
            ST_RELOAD: begin
               out            <= rif.initval;
               rif.reload_ack <= 1'b1;
               state          <= ST_ACK_WAIT;
`ifdef SATURATE_EN
               sat            <= 1'b0;
`endif
            end
            ST_ACK_WAIT: begin
               if (!rif.reload_req) begin
                  rif.reload_ack <= 1'b0;
                  if (HOLDOFF == 0) begin
                     state <= ST_COUNT;
                  end else begin
                     hold_cnt <= HW'(HOLDOFF);
                     state    <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               // A fresh request abandons the current window; it restarts
               // in full after the next handshake.
               if (rif.reload_req) begin
                  hold_cnt <= '0;
                  state    <= ST_RELOAD;
               end else if (hold_cnt == HW'(1)) begin
                  hold_cnt <= '0;
                  state    <= ST_COUNT;
               end else begin
                  hold_cnt <= hold_cnt - HW'(1);
               end
            end
            default: state <= ST_COUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_reload_counter.sv
// Scoreboard bench for reload_counter: the driver steps a behavioural model
// each cycle and queues the expected outputs; the monitor pops and compares.
module tb_reload_counter;

   localparam int SIZE    = 8;
   localparam int STEP    = 1;
   localparam int HOLDOFF = 2;
   localparam int MOD     = 1 << SIZE;
   localparam int MAXV    = MOD - 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            en = 1'b0;
   logic [SIZE-1:0] out;
   logic            wrap;
   logic            busy;

   reload_counter_if #(.SIZE(SIZE)) rif ();

   reload_counter #(.SIZE(SIZE), .STEP(STEP), .HOLDOFF(HOLDOFF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .rif   (rif.slave),
      .out   (out),
      .wrap  (wrap),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [SIZE-1:0] out;
      logic            wrap;
      logic            ack;
      logic            busy;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: a pending load, an open handshake, remaining frozen cycles.
   int m_out;
   bit m_wrap, m_ack, m_sat, m_loading, m_open;
   int m_hold;

   function automatic void m_reset();
      m_out = 0; m_wrap = 0; m_ack = 0; m_sat = 0;
      m_loading = 0; m_open = 0; m_hold = 0;
   endfunction

   function automatic void m_step(bit req, bit en_i, int init);
      m_wrap = 0;
      if (m_loading) begin
         m_out = init % MOD;
         m_ack = 1; m_loading = 0; m_open = 1; m_sat = 0;
      end else if (m_open) begin
         if (!req) begin
            m_ack = 0; m_open = 0; m_hold = HOLDOFF;
         end
      end else if (m_hold > 0) begin
         if (req) begin
            m_loading = 1; m_hold = 0;
         end else begin
            m_hold--;
         end
      end else if (req) begin
         m_loading = 1;
      end else if (en_i) begin
         if (m_out + STEP >= MOD) begin
`ifdef SATURATE_EN
            m_out = MAXV;
            if (!m_sat) m_wrap = 1;
            m_sat = 1;
`else
            m_out = (m_out + STEP) % MOD;
            m_wrap = 1;
`endif
         end else begin
            m_out = m_out + STEP;
         end
      end
   endfunction

   function automatic exp_t m_exp();
      exp_t e;
      e.out  = m_out[SIZE-1:0];
      e.wrap = m_wrap;
      e.ack  = m_ack;
      e.busy = m_loading | m_open | (m_hold > 0);
      return e;
   endfunction

   task automatic cyc(input bit req, input bit en_i, input int init);
      @(negedge clk);
      rst_n          = 1'b1;
      rif.reload_req = req;
      en             = en_i;
      rif.initval    = init[SIZE-1:0];
      m_step(req, en_i, init);
      sb.push_back(m_exp());
   endtask

   task automatic rst_cyc();
      @(negedge clk);
      rst_n          = 1'b0;
      rif.reload_req = 1'b0;
      en             = 1'b0;
      m_reset();
      sb.push_back(m_exp());
   endtask

   task automatic handshake(input int init, input int linger, input bit en_i);
      cyc(1, en_i, init);
      cyc(1, en_i, init);
      for (int k = 0; k < linger; k++) cyc(1, en_i, init);
      cyc(0, en_i, init);
   endtask

   task automatic check_now(input string name, input int act, input int req_v);
      checks++;
      if (act != req_v) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
      end
   endtask

   // Monitor: compare DUT outputs after every rising edge against the queue.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if ({out, wrap, rif.reload_ack, busy} !== e) begin
            failures++;
            $display("FAIL snapshot t=%0t actual out=%h wrap=%b ack=%b busy=%b required out=%h wrap=%b ack=%b busy=%b",
                     $time, out, wrap, rif.reload_ack, busy, e.out, e.wrap, e.ack, e.busy);
         end
      end
   end

   initial begin
      bit r_req;
      int linger;
      bit hs;

      rif.reload_req = 1'b0;
      rif.initval    = '0;
      m_reset();

      // reset then free count 1..5
      for (int i = 0; i < 3; i++) rst_cyc();
      for (int i = 0; i < 5; i++) cyc(0, 1, 0);

      // handshake from 5 to 2, req lingers 3 cycles, then counts 3,4
      handshake(8'h02, 3, 1'b1);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0);

      // advance to 7, then req and en together: no increment, load 0
      for (int i = 0; i < 3; i++) cyc(0, 1, 0);
      handshake(8'h00, 0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0);

      // wrap boundary from FE
      handshake(8'hFE, 1, 1'b0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 0);

      // re-request in first HOLD cycle
      handshake(8'h02, 0, 1'b1);
      cyc(1, 1, 8'h09);
      cyc(1, 1, 8'h09);
      cyc(0, 1, 8'h09);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0);

      // protocol violation: req drops while the load is pending
      cyc(1, 1, 8'h33);
      cyc(0, 1, 8'h33);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0);

      // asynchronous reset while in ACK_WAIT
      cyc(1, 0, 8'h44);
      cyc(1, 0, 8'h44);
      cyc(1, 0, 8'h44);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_now("async_rst_out", int'(out), 0);
      check_now("async_rst_ack", int'(rif.reload_ack), 0);
      check_now("async_rst_busy", int'(busy), 0);
      m_reset();
      sb.push_back(m_exp());
      rst_cyc();
      for (int i = 0; i < 4; i++) cyc(0, 1, 0);

      // randomized traffic obeying the initiator rules
      r_req = 0; hs = 0; linger = 0;
      for (int i = 0; i < 3000; i++) begin
         int ival;
         ival = ($urandom_range(3) == 0) ? (MAXV - int'($urandom_range(3))) : int'($urandom_range(MAXV));
         if ($urandom_range(499) == 0) begin
            rst_cyc();
            r_req = 0; hs = 0;
            continue;
         end
         if (!hs) begin
            if (!m_ack && !m_loading && $urandom_range(11) == 0) begin
               r_req = 1; hs = 1; linger = $urandom_range(3);
            end
         end else if (m_ack) begin
            if (linger == 0) begin
               r_req = 0; hs = 0;
            end else begin
               linger--;
            end
         end else if ($urandom_range(29) == 0) begin
            r_req = 0; hs = 0;
         end
         cyc(r_req, $urandom_range(3) != 0, ival);
      end
      cyc(0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
